reg_file_mp: RTL and testbench

// - Parametrised multi-port register file for the next CPU core generation (superscalar/dual-issue datapath).
// - Provides NUM_RD combinational read ports and two synchronous write ports.
// - Register 0 is hard-wired to zero, and same-cycle write data can be forwarded to reads.
// - Reset triggers a sequential clear sequence; the `ready` output gates use of the file.

---
 rtl/reg_file_mp.sv | 83 ++++++++
 tb/tb_reg_file_mp.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD async reads, two sync writes, clear-on-reset.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to read ports.
module reg_file_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     ready,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clrCnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic wr0Ok;
    logic wr1Ok;

    // Port 1 wins an address collision, so port 0 backs off.
    assign wr1Ok = we1 && (wa1 != '0);
    assign wr0Ok = we0 && (wa0 != '0) && !(we1 && (wa1 == wa0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= CLEAR;
            clrCnt <= '0;
            ready  <= 1'b0;
        end else begin
            unique case (state)
                CLEAR: begin
                    mem[clrCnt] <= '0;
                    clrCnt      <= clrCnt + ADDR_W'(1);
                    if (clrCnt == ADDR_W'(DEPTH - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (wr0Ok) mem[wa0] <= wd0;
                    if (wr1Ok) mem[wa1] <= wd1;
                end
                default: state <= CLEAR;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : gRd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;

        assign addr = ra[k*ADDR_W +: ADDR_W];

        always_comb begin
            data = mem[addr];
`ifdef REGFILE_BYPASS_EN
            if (state == RUN) begin
                if (we1 && (wa1 == addr)) data = wd1;
                else if (we0 && (wa0 == addr)) data = wd0;
            end
`endif
            if ((addr == '0) || !ready) data = '0;
        end

        assign rd[k*DATA_W +: DATA_W] = data;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: directed stimulus, decoupled negedge monitor.
module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           ready;
    logic           we0 = 1'b0;
    logic [AW-1:0]  wa0 = '0;
    logic [DW-1:0]  wd0 = '0;
    logic           we1 = 1'b0;
    logic [AW-1:0]  wa1 = '0;
    logic [DW-1:0]  wd1 = '0;
    logic [NR*AW-1:0] ra = '0;
    logic [NR*DW-1:0] rd;

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra), .rd(rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
        logic          eRdy;
    } exp_t;

    exp_t rdQ[$];
    int   latQ[$];
    int   errors = 0;
    int   checks = 0;
    logic chk = 1'b0;
    int   lat = 0;
    logic prevRdy = 1'b0;

    always @(posedge clk) begin
        if (rst) lat <= 0;
        else lat <= lat + 1;
    end

    always @(negedge clk) begin
        if (chk) begin
            if (rdQ.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL monitor: check requested, scoreboard empty");
            end else begin
                exp_t e;
                e = rdQ.pop_front();
                checks += 3;
                if (rd[DW-1:0] !== e.e0) begin
                    errors++;
                    $display("FAIL %s rd0: got %h want %h", e.name, rd[DW-1:0], e.e0);
                end
                if (rd[2*DW-1:DW] !== e.e1) begin
                    errors++;
                    $display("FAIL %s rd1: got %h want %h", e.name, rd[2*DW-1:DW], e.e1);
                end
                if (ready !== e.eRdy) begin
                    errors++;
                    $display("FAIL %s ready: got %b want %b", e.name, ready, e.eRdy);
                end
            end
        end
        if (ready === 1'b1 && prevRdy !== 1'b1) begin
            checks++;
            if (latQ.size() == 0) begin
                errors++;
                $display("FAIL latency: unexpected ready rise, lat=%0d", lat);
            end else begin
                int want;
                want = latQ.pop_front();
                if (lat != want) begin
                    errors++;
                    $display("FAIL latency: got %0d want %0d", lat, want);
                end
            end
        end
        prevRdy = ready;
    end

    task automatic check(input string name, input logic [AW-1:0] a0,
                         input logic [AW-1:0] a1, input logic [DW-1:0] e0,
                         input logic [DW-1:0] e1, input logic eRdy);
        exp_t e;
        e.name = name;
        e.e0 = e0;
        e.e1 = e1;
        e.eRdy = eRdy;
        ra = {a1, a0};
        rdQ.push_back(e);
        chk = 1'b1;
        @(negedge clk);
        #1 chk = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        we0 = e0; wa0 = a0; wd0 = d0;
        we1 = e1; wa1 = a1; wd1 = d1;
    endtask

    task automatic idle();
        wr(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic pulseRst();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic waitReady();
        int n = 0;
        while (ready !== 1'b1 && n < 200) begin
            cyc();
            n++;
        end
        if (ready !== 1'b1) begin
            errors++;
            checks++;
            $display("FAIL waitReady: timeout, ready=%b want 1", ready);
        end
    endtask

    initial begin
        repeat (3) cyc();
        check("reset", 5'd5, 5'd3, 32'h0, 32'h0, 1'b0);
        latQ.push_back(32);
        cyc();
        rst = 1'b0;
        waitReady();
        cyc();

        check("zero0", 5'd0, 5'd1, 32'h0, 32'h0, 1'b1);
        check("zero31", 5'd31, 5'd5, 32'h0, 32'h0, 1'b1);

        cyc();
        wr(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        check("wr5_same", 5'd5, 5'd6, BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 1'b1);
        cyc();
        idle();
        check("wr5_next", 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);

        cyc();
        wr(1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7, 32'h22222222);
        check("coll_same", 5'd7, 5'd5, BYP ? 32'h22222222 : 32'h0, 32'hDEADBEEF, 1'b1);
        cyc();
        idle();
        check("coll_next", 5'd7, 5'd7, 32'h22222222, 32'h22222222, 1'b1);

        cyc();
        wr(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFFFFFF);
        check("a0_same", 5'd0, 5'd0, 32'h0, 32'h0, 1'b1);
        cyc();
        idle();
        check("a0_next", 5'd0, 5'd7, 32'h0, 32'h22222222, 1'b1);

        cyc();
        wr(1'b1, 5'd9, 32'h09090909, 1'b1, 5'd31, 32'hA0A0A0A0);
        check("dual_same", 5'd9, 5'd31, BYP ? 32'h09090909 : 32'h0,
              BYP ? 32'hA0A0A0A0 : 32'h0, 1'b1);
        cyc();
        wr(1'b1, 5'd3, 32'h12345678, 1'b0, '0, '0);
        check("dual_next", 5'd9, 5'd31, 32'h09090909, 32'hA0A0A0A0, 1'b1);
        cyc();
        idle();
        check("reg3", 5'd3, 5'd9, 32'h12345678, 32'h09090909, 1'b1);

        pulseRst();
        check("clr_gate", 5'd3, 5'd5, 32'h0, 32'h0, 1'b0);
        repeat (9) cyc();
        check("clr_mid", 5'd3, 5'd31, 32'h0, 32'h0, 1'b0);
        latQ.push_back(32);
        pulseRst();
        waitReady();
        cyc();
        check("after_clr", 5'd3, 5'd5, 32'h0, 32'h0, 1'b1);

        cyc();
        wr(1'b1, 5'd3, 32'h12345678, 1'b0, '0, '0);
        cyc();
        idle();
        check("reg3_again", 5'd3, 5'd0, 32'h12345678, 32'h0, 1'b1);
        latQ.push_back(32);
        pulseRst();
        wr(1'b1, 5'd4, 32'h000000AA, 1'b0, '0, '0);
        repeat (5) cyc();
        check("clr_we", 5'd4, 5'd4, 32'h0, 32'h0, 1'b0);
        waitReady();
        idle();
        cyc();
        check("reg4_ign", 5'd4, 5'd4, 32'h0, 32'h0, 1'b1);
        check("reg3_clr", 5'd3, 5'd7, 32'h0, 32'h0, 1'b1);

        repeat (2) cyc();
        if (rdQ.size() != 0 || latQ.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d rd and %0d latency expectations left, want 0",
                     rdQ.size(), latQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
